// File: rtl/sram22_port_ctrl.sv
// ============================================================================
// Module   : sram22_port_ctrl
// Purpose  : Valid/ready request port in front of a registered-output SRAM
//            macro, with a 3-entry in-order response FIFO and credit flow.
// Options  : define SRAM22_PORT_CTRL_WACK_EN to return a zero-data write ack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram22_port_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

`ifdef SRAM22_PORT_CTRL_WACK_EN
    localparam bit c_wack_en = 1'b1;
`else
    localparam bit c_wack_en = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] fifo_q [0:2];
    logic [DATA_WIDTH-1:0] fifo_d [0:2];
    logic [1:0]            count_q, count_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  wack_q, wack_d;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_used;
    logic [DATA_WIDTH-1:0] w_push_data;

    // Credits count the pending macro read too, so the FIFO can never overflow.
    assign w_used    = {1'b0, count_q} + {2'b00, rd_pend_q};
    assign req_ready = !rst && (w_used < 3'd3);
    assign w_accept  = req_valid && req_ready;

    assign sram_we    = w_accept && req_we;
    assign sram_wmask = sram_we ? req_wmask : '0;
    assign sram_addr  = req_addr;
    assign sram_din   = req_wdata;

    assign rsp_valid = (count_q != 2'd0);
    assign rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q] : '0;

    assign w_push      = rd_pend_q;
    assign w_pop       = rsp_valid && rsp_ready;
    assign w_push_data = wack_q ? '0 : sram_dout;

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_pend_d = w_accept && (!req_we || c_wack_en);
        wack_d    = w_accept && req_we && c_wack_en;
        if (w_push) begin
            fifo_d[wr_ptr_q] = w_push_data;
            wr_ptr_d         = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fifo_q[2] <= '0;
            count_q   <= 2'd0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            rd_pend_q <= 1'b0;
            wack_q    <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_pend_q <= rd_pend_d;
            wack_q    <= wack_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram22_port_ctrl.sv
// ============================================================================
// Module   : tb_sram22_port_ctrl
// Purpose  : Directed self-checking bench for sram22_port_ctrl with a
//            behavioural registered-output SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram22_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_wmask = 4'h0;
    logic [5:0]  req_addr = 6'd0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [5:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:63];

    sram22_port_ctrl #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (6),
        .WMASK_WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_we   (sram_we),
        .sram_wmask(sram_wmask),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (sram_we && sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
        end
        sram_dout <= mem[sram_addr];
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 9) ? 32'h0 : 32'hC0DE_0000 + 32'(i) * 32'h0101;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request and returns just after the edge that accepts it.
    task automatic issue(input logic we, input logic [5:0] addr,
                         input logic [31:0] data, input logic [3:0] mask);
        logic ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        if (!ok) check("issue_timeout", {31'b0, ok}, 32'd1);
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                seen = 1'b1;
                check(tag, rsp_rdata, exp);
            end
            @(posedge clk);
            #1;
        end
        if (!seen) check({tag, "_timeout"}, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int t0, t1;
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full write then read-after-write, 2-edge latency
        issue(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 6'd5, 32'h0, 4'h0);
        @(negedge clk);
`ifdef SRAM22_PORT_CTRL_WACK_EN
        check("wack_valid", {31'b0, rsp_valid}, 32'd1);
        check("wack_data", rsp_rdata, 32'h0);
`else
        check("raw_lat1_valid", {31'b0, rsp_valid}, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        check("raw_lat2_valid", {31'b0, rsp_valid}, 32'd1);
        check("raw_data", rsp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Partial byte-mask write
        issue(1'b1, 6'd9, 32'h11223344, 4'h5);
        issue(1'b0, 6'd9, 32'h0, 4'h0);
`ifdef SRAM22_PORT_CTRL_WACK_EN
        get_rsp("pmask_wack", 32'h0);
`endif
        get_rsp("pmask_data", 32'h00220044);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: three credits, fourth read stalls
        rsp_ready = 1'b0;
        issue(1'b0, 6'd1, 32'h0, 4'h0);
        issue(1'b0, 6'd2, 32'h0, 4'h0);
        issue(1'b0, 6'd3, 32'h0, 4'h0);
        req_valid = 1'b1;
        req_addr  = 6'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", {31'b0, req_ready}, 32'd0);
            check("bp_hold_data", rsp_rdata, init_word(1));
            @(posedge clk);
            #1;
        end
        fork
            issue(1'b0, 6'd4, 32'h0, 4'h0);
            begin
                rsp_ready = 1'b1;
                get_rsp("bp_rsp1", init_word(1));
                get_rsp("bp_rsp2", init_word(2));
                get_rsp("bp_rsp3", init_word(3));
                get_rsp("bp_rsp4", init_word(4));
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Throughput: 16 back-to-back reads
        t0 = 0;
        t1 = 0;
        fork
            for (int i = 0; i < 16; i++) begin
                issue(1'b0, 6'(16 + i), 32'h0, 4'h0);
                if (i == 0) t0 = cyc;
                if (i == 15) t1 = cyc;
            end
            for (int i = 0; i < 16; i++) get_rsp("tput_data", init_word(16 + i));
        join
        check("tput_cycles", 32'(t1 - t0), 32'd15);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-stream with two reads buffered
        rsp_ready = 1'b0;
        issue(1'b0, 6'd1, 32'h0, 4'h0);
        issue(1'b0, 6'd2, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        check("mrst_pre_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_valid", {31'b0, rsp_valid}, 32'd0);
        check("mrst_ready", {31'b0, req_ready}, 32'd0);
        check("mrst_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrst_release_ready", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mrst_no_stale", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        issue(1'b0, 6'd7, 32'h0, 4'h0);
        get_rsp("mrst_fresh", init_word(7));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram22_port_ctrl.md
SRAM22_PORT_CTRL -- requirements
Module: sram22_port_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, read/write data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, word address width (64 words).
REQ-003 The block SHALL have parameter WMASK_WIDTH, default 4, byte-lane mask width (DATA_WIDTH/8).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-007 Port req_valid: input, 1 bit, the request is present.
REQ-008 Port req_ready: output, 1 bit, the block can accept a request.
REQ-009 Port req_we: input, 1 bit, 1 = write, 0 = read.
REQ-010 Port req_wmask: input, WMASK_WIDTH bits, byte-lane write enables.
REQ-011 Port req_addr: input, ADDR_WIDTH bits, word address.
REQ-012 Port req_wdata: input, DATA_WIDTH bits, write data.
REQ-013 Port rsp_valid: output, 1 bit, a response is present.
REQ-014 Port rsp_ready: input, 1 bit, the consumer accepts the response.
REQ-015 Port rsp_rdata: output, DATA_WIDTH bits, response data.
REQ-016 Ports sram_we (1 bit), sram_wmask, sram_addr and sram_din: outputs that drive the macro's we, wmask, addr and din.
REQ-017 Port sram_dout: input, DATA_WIDTH bits, the macro's registered read data, valid the cycle after a read edge.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid && req_ready.
REQ-019 The SRAM outputs SHALL be combinational pass-through of the request fields, so the macro samples the request on the same edge that accepts it.
REQ-020 sram_we SHALL equal req_valid && req_ready && req_we.
- sram_wmask SHALL be req_wmask when sram_we is 1, and 0 otherwise.
- Non-accepted cycles therefore present a read, which is harmless.
REQ-021 An accepted read SHALL set rd_pend.
- On the next edge, sram_dout SHALL be pushed into a 3-entry response FIFO.
- rd_pend SHALL then clear, unless another read was accepted on that edge.
REQ-022 Read latency SHALL be exactly 2 edges: a read accepted at edge T raises rsp_valid after edge T+1 when the FIFO was empty.
REQ-023 req_ready SHALL be high when (FIFO count + rd_pend) < 3, and low during reset.
- req_ready SHALL have no combinational dependence on rsp_ready or req_valid.
REQ-024 A FIFO push and a pop (rsp_valid && rsp_ready) on the same edge SHALL both take effect, leaving the count unchanged.
REQ-025 Responses SHALL return in request order; the FIFO read/write pointers SHALL wrap modulo 3.
REQ-026 rsp_valid and rsp_rdata SHALL hold stable while rsp_valid && !rsp_ready.
REQ-027 A read accepted on the edge after a write to the same address SHALL return the newly written bytes, merged per wmask.
REQ-028 With rsp_ready held high, back-to-back reads SHALL sustain one accepted request per cycle.

Reset
REQ-029 While rst is high, the FIFO SHALL be emptied, rd_pend cleared, rsp_valid = 0, rsp_rdata = 0 and req_ready = 0.
REQ-030 Reset asserted mid-operation SHALL discard pending and buffered reads without emitting a response.
REQ-031 req_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-032 Macro SRAM22_PORT_CTRL_WACK_EN SHALL select whether writes return an acknowledge response.
REQ-033 When SRAM22_PORT_CTRL_WACK_EN is defined:
- each accepted write SHALL also push a response with rsp_rdata = 0, with the same 2-edge latency;
- the response SHALL be ordered with reads;
- a write SHALL consume a credit under REQ-023.
REQ-034 When SRAM22_PORT_CTRL_WACK_EN is undefined, writes SHALL produce no response and SHALL not consume credits.

Verification
REQ-035 Reset case: with rst pulsed mid-stream with 2 reads buffered, the response SHALL be rsp_valid = 0 after the pulse, no stale responses, and req_ready = 1 after release.
REQ-036 Write/read case: a write to addr 5 of 0xDEADBEEF, wmask 0xF, followed next cycle by a read of 5 SHALL yield rsp_rdata = 0xDEADBEEF 2 edges after the read.
REQ-037 Partial-mask case: a write of 0x11223344 with wmask 0x5 to a zeroed addr 9, then a read of 9, SHALL yield 0x00220044.
REQ-038 Backpressure case: with rsp_ready = 0, issuing 4 reads SHALL accept exactly 3 and drop req_ready.
- After rsp_ready rises, the 3 responses SHALL drain in order and the 4th read SHALL be accepted.
REQ-039 Throughput case: 16 consecutive reads with rsp_ready = 1 SHALL be accepted in 16 cycles and return data in address order.
REQ-040 Write-ack case: with SRAM22_PORT_CTRL_WACK_EN defined, a write then a read SHALL produce two responses, 0x0 then the read data.
